fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage front end: owns the fetch PC and drives the F-side inputs of the IF/ID pipeline register (`inst_F`, `PC_F`, `PCplus4_F`). It also runs a single-outstanding request/grant/response handshake to instruction memory. It honours `Stall_F` from the hazard unit and `PCSrc_E`/`PCTarget_E` redirects from Execute. When no valid instruction is available, it presents a NOP bubble.

## Interface
- `PC_WIDTH`, 32, PC and address width
- `INST_WIDTH`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `NOP_INST`, 32'h00000013, bubble encoding (addi x0,x0,0)

- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Stall_F`  in  1  hold current fetch PC/instruction
- `PCSrc_E`  in  1  redirect request from Execute
- `PCTarget_E`  in  PC_WIDTH  redirect target
- `imem_req`  out  1  memory request valid
- `imem_addr`  out  PC_WIDTH  request address
- `imem_gnt`  in  1  request accepted this cycle (req&&gnt)
- `imem_rvalid`  in  1  response valid, ≥1 cycle after its grant, in order
- `imem_rdata`  in  INST_WIDTH  response instruction
- `inst_F`  out  INST_WIDTH  instruction to IF/ID (NOP_INST when not valid)
- `PC_F`  out  PC_WIDTH  address of `inst_F`
- `PCplus4_F`  out  PC_WIDTH  `PC_F + 4`, modulo 2^PC_WIDTH
- `inst_valid_F`  out  1  `inst_F` is a real fetched instruction

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. At most one request is outstanding.
- Reset values:
  - state = IDLE, `PC_F` = RESET_PC, hold buffer = NOP_INST.
  - `imem_req` = 0, `imem_addr` = RESET_PC.
  - `inst_F` = NOP_INST, `inst_valid_F` = 0.
- IDLE: no request. Go to REQ next cycle unconditionally.
- REQ: `imem_req` = 1, `imem_addr` = `PC_F`.
  - gnt and no redirect → WAIT.
  - gnt with `PCSrc_E` → DROP, because the granted request is stale.
  - No gnt: stay. The address may change without a grant.
- WAIT: `imem_req` = 0 unless the issue-ahead case below applies. `imem_rvalid` is observed in this state.
  - rvalid, `Stall_F` = 0, no redirect:
    - Present `inst_F` = `imem_rdata` with `inst_valid_F` = 1 (combinational pass-through), and `PC_F` <= `PC_F` + 4.
    - Issue ahead in the same cycle: `imem_req` = 1, `imem_addr` = `PC_F` + 4.
    - gnt → stay in WAIT; no gnt → REQ.
  - rvalid with `Stall_F` = 1: latch `imem_rdata` into the hold buffer and go to HOLD. The instruction is still presented this cycle with valid = 1.
  - No rvalid: `inst_valid_F` = 0, `inst_F` = NOP_INST.
- HOLD: `inst_F` = hold buffer, `inst_valid_F` = 1, no request.
  - When `Stall_F` = 0: `PC_F` <= `PC_F` + 4 and go to REQ.
- DROP: discard the next rvalid, then go to REQ. `inst_valid_F` = 0.
- Redirect (`PCSrc_E` = 1) takes priority over `Stall_F` in every state:
  - `PC_F` <= `PCTarget_E`, `inst_valid_F` = 0 that cycle, and the hold buffer is invalidated.
  - Next state:
    - REQ, no gnt → REQ.
    - REQ, gnt → DROP.
    - WAIT, no rvalid → DROP.
    - WAIT, rvalid → REQ.
    - HOLD → REQ.
    - DROP → DROP if its rvalid has not yet arrived, else REQ.
  - No issue-ahead is performed on a redirect cycle.
- `Stall_F` in REQ does not block issuing. Only consumption of a response is gated.
- `PC_F` wraps modulo 2^PC_WIDTH. Alignment is not checked.

## Timing
- Zero-wait memory (gnt = 1, rvalid one cycle after grant) gives:
  - the first valid `inst_F` 2 cycles after reset release (IDLE, REQ, then WAIT+rvalid);
  - one instruction per cycle thereafter.
- Redirect to first target instruction: 2 cycles with no stale response pending, or 3 cycles through DROP.
- `inst_F`, `inst_valid_F` and `imem_req` depend combinationally on `imem_rvalid`, `imem_gnt`, `Stall_F` and `PCSrc_E`. All state and `PC_F` update on `posedge clk`.
- Reset asserted mid-request returns to IDLE immediately. A response arriving after reset release while in IDLE is ignored; the memory side must be reset together with this block.

## Structure
- Shared pipeline package holds the state enum (`FETCH_IDLE`…`FETCH_DROP`) and the `NOP_INST` constant, which is shared with decode/hazard logic.
- No sub-module is needed. The hold buffer is a single register inside `fetch_unit`.

## Test plan
1. Reset with RESET_PC = 0 and zero-wait memory, `Stall_F` = 0 → `imem_addr` sequence 0, 4, 8, 12. `inst_valid_F` goes high from cycle 2 with one instruction per cycle, and `PCplus4_F` = `PC_F` + 4.
2. `Stall_F` held 3 cycles while rvalid returns the instruction at 0x8 → `inst_F` stays that word with valid = 1 and `PC_F` = 0x8 throughout. After release, the next request address is 0xC.
3. `PCSrc_E` with `PCTarget_E` = 0x100 while in WAIT, rvalid 2 cycles later → the stale response is dropped (valid = 0), then request 0x100, and the next valid `inst_F` carries `PC_F` = 0x100.
4. `imem_gnt` held low for 4 cycles → `imem_req` stays 1 with `imem_addr` stable and `inst_F` = 0x00000013 with valid = 0. No PC advance.
5. Redirect and `Stall_F` asserted together in HOLD → the redirect wins: `PC_F` = target, the hold buffer is discarded, and the state goes to REQ.
6. `rst_n` pulsed low in WAIT → all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding and the bubble instruction
// that decode/hazard logic also recognise.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_DROP
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response channel; fetch drives the master side.
interface fetch_unit_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch-stage front end: owns PC_F, keeps one imem request in flight and feeds
// the F side of IF/ID, substituting a NOP bubble whenever nothing valid is ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(fetch_unit_pkg::NOP_INST)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Stall_F,
  input  logic                  PCSrc_E,
  input  logic [PC_WIDTH-1:0]   PCTarget_E,
  fetch_unit_if.master          imem,
  output logic [INST_WIDTH-1:0] inst_F,
  output logic [PC_WIDTH-1:0]   PC_F,
  output logic [PC_WIDTH-1:0]   PCplus4_F,
  output logic                  inst_valid_F
);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] hold_q, hold_d;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic                  req;
  logic [PC_WIDTH-1:0]   addr;
  logic [INST_WIDTH-1:0] inst;
  logic                  vld;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    req     = 1'b0;
    addr    = pc_q;
    inst    = NOP_INST;
    vld     = 1'b0;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        // Address may move under a pending request, so no grant means just retry.
        req = 1'b1;
        if (imem.imem_gnt) state_d = PCSrc_E ? FETCH_DROP : FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (PCSrc_E) begin
          state_d = imem.imem_rvalid ? FETCH_REQ : FETCH_DROP;
        end else if (imem.imem_rvalid) begin
          inst = imem.imem_rdata;
          vld  = 1'b1;
          if (Stall_F) begin
            hold_d  = imem.imem_rdata;
            state_d = FETCH_HOLD;
          end else begin
            // Issue-ahead keeps zero-wait memory at one instruction per cycle.
            pc_d    = pc_plus4;
            req     = 1'b1;
            addr    = pc_plus4;
            state_d = imem.imem_gnt ? FETCH_WAIT : FETCH_REQ;
          end
        end
      end
      FETCH_HOLD: begin
        if (PCSrc_E) begin
          state_d = FETCH_REQ;
        end else begin
          inst = hold_q;
          vld  = 1'b1;
          if (!Stall_F) begin
            pc_d    = pc_plus4;
            state_d = FETCH_REQ;
          end
        end
      end
      FETCH_DROP: if (imem.imem_rvalid) state_d = FETCH_REQ;
      default:    state_d = FETCH_IDLE;
    endcase
    // A redirect beats a stall everywhere and kills any held instruction.
    if (PCSrc_E) begin
      pc_d   = PCTarget_E;
      hold_d = NOP_INST;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign inst_F         = inst;
  assign inst_valid_F   = vld;
  assign PC_F           = pc_q;
  assign PCplus4_F      = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scripted memory plus a stream-level model that
// predicts which PC/instruction must appear next, checked every cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall_F = 1'b0;
  logic        PCSrc_E = 1'b0;
  logic [31:0] PCTarget_E = '0;
  logic [31:0] inst_F, PC_F, PCplus4_F;
  logic        inst_valid_F;

  fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) imem_if ();

  fetch_unit #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Stall_F      (Stall_F),
    .PCSrc_E      (PCSrc_E),
    .PCTarget_E   (PCTarget_E),
    .imem         (imem_if),
    .inst_F       (inst_F),
    .PC_F         (PC_F),
    .PCplus4_F    (PCplus4_F),
    .inst_valid_F (inst_valid_F)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } rsp_t;

  rsp_t        q[$];
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic [31:0] exp_pc = '0;
  int          outst = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Stream model: valid instructions must walk PC by 4, restart at a redirect
  // target, repeat while stalled, and carry the memory word of their own PC.
  always @(negedge clk or negedge rst_n) begin : cmp
    rsp_t r;
    if (!rst_n) begin
      q.delete();
      cyc    = 0;
      exp_pc = 32'h0;
      outst  = 0;
    end else begin
      chk("pcplus4", PCplus4_F, PC_F + 32'd4);
      if (!inst_valid_F) chk("bubble", inst_F, NOP);
      if (PCSrc_E) chkb("redirect_kill", inst_valid_F, 1'b0);
      if (inst_valid_F) begin
        chk("pc_stream", PC_F, exp_pc);
        chk("inst_data", inst_F, memword(PC_F));
      end
      if (imem_if.imem_req) begin
        chk("req_addr", imem_if.imem_addr, inst_valid_F ? PC_F + 32'd4 : PC_F);
        if (inst_valid_F) chkb("issue_while_stalled", Stall_F, 1'b0);
      end
      if (imem_if.imem_rvalid) begin
        void'(q.pop_front());
        outst--;
      end
      if (imem_if.imem_req && imem_if.imem_gnt) begin
        r.addr = imem_if.imem_addr;
        r.rdy  = cyc + lat;
        q.push_back(r);
        outst++;
      end
      chkb("single_outstanding", outst <= 1, 1'b1);
      if (PCSrc_E) exp_pc = PCTarget_E;
      else if (inst_valid_F && !Stall_F) exp_pc = exp_pc + 32'd4;
      cyc++;
    end
  end

  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    Stall_F          = st;
    PCSrc_E          = rd;
    PCTarget_E       = tgt;
    imem_if.imem_gnt = gnt_en;
    if (q.size() > 0 && q[0].rdy <= cyc) begin
      imem_if.imem_rvalid = 1'b1;
      imem_if.imem_rdata  = memword(q[0].addr);
    end else begin
      imem_if.imem_rvalid = 1'b0;
      imem_if.imem_rdata  = 32'hBAD0_BAD0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic release_rst;
    @(posedge clk);
    #1;
    rst_n               = 1'b1;
    Stall_F             = 1'b0;
    PCSrc_E             = 1'b0;
    imem_if.imem_gnt    = gnt_en;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic rq);
    chkb({name, "_valid"}, inst_valid_F, v);
    chk({name, "_pc"}, PC_F, pc);
    chk({name, "_inst"}, inst_F, inst);
    chkb({name, "_req"}, imem_if.imem_req, rq);
  endtask

  initial begin
    imem_if.imem_gnt    = 1'b1;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = '0;
    #3;
    expect_out("reset", 1'b0, 32'h0, NOP, 1'b0);
    chk("reset_addr", imem_if.imem_addr, 32'h0);

    // Zero-wait streaming from reset
    release_rst();
    expect_out("c0_idle", 1'b0, 32'h0, NOP, 1'b0);
    step(0, 0, 0);
    expect_out("c1_req", 1'b0, 32'h0, NOP, 1'b1);
    chk("c1_addr", imem_if.imem_addr, 32'h0);
    step(0, 0, 0);
    expect_out("c2_first", 1'b1, 32'h0, 32'hDEAD_0000, 1'b1);
    chk("c2_addr", imem_if.imem_addr, 32'h4);
    step(0, 0, 0);
    chk("c3_addr", imem_if.imem_addr, 32'h8);

    // Stall for three cycles on the word at 0x8
    step(1, 0, 0);
    expect_out("stall0", 1'b1, 32'h8, 32'hDEAD_0008, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0);
      expect_out("stall_hold", 1'b1, 32'h8, 32'hDEAD_0008, 1'b0);
    end
    step(0, 0, 0);
    expect_out("stall_rel", 1'b1, 32'h8, 32'hDEAD_0008, 1'b0);
    lat = 2;
    step(0, 0, 0);
    expect_out("after_stall", 1'b0, 32'hC, NOP, 1'b1);
    chk("after_stall_addr", imem_if.imem_addr, 32'hC);

    // Redirect in WAIT; stale response lands in DROP
    step(0, 1, 32'h100);
    expect_out("redir_wait", 1'b0, 32'hC, NOP, 1'b0);
    step(0, 0, 0);
    expect_out("drop", 1'b0, 32'h100, NOP, 1'b0);
    step(0, 0, 0);
    chk("tgt_addr", imem_if.imem_addr, 32'h100);
    chkb("tgt_req", imem_if.imem_req, 1'b1);
    lat = 1;
    step(0, 0, 0);
    chkb("tgt_wait_valid", inst_valid_F, 1'b0);
    step(0, 0, 0);
    expect_out("tgt_first", 1'b1, 32'h100, 32'hDEAD_0100, 1'b1);

    // Grant withheld for four cycles
    gnt_en = 1'b0;
    step(0, 0, 0);
    expect_out("nogrant0", 1'b1, 32'h104, 32'hDEAD_0104, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      expect_out("nogrant", 1'b0, 32'h108, NOP, 1'b1);
      chk("nogrant_addr", imem_if.imem_addr, 32'h108);
    end
    gnt_en = 1'b1;
    step(0, 0, 0);
    chk("regrant_addr", imem_if.imem_addr, 32'h108);

    // Redirect and stall together while holding
    step(1, 0, 0);
    expect_out("to_hold", 1'b1, 32'h108, 32'hDEAD_0108, 1'b0);
    step(1, 1, 32'h200);
    expect_out("hold_redir", 1'b0, 32'h108, NOP, 1'b0);
    step(1, 0, 0);
    expect_out("req_under_stall", 1'b0, 32'h200, NOP, 1'b1);
    chk("req_under_stall_addr", imem_if.imem_addr, 32'h200);
    lat = 2;
    step(0, 0, 0);
    expect_out("tgt2_first", 1'b1, 32'h200, 32'hDEAD_0200, 1'b1);
    step(0, 0, 0);
    chkb("wait_empty", inst_valid_F, 1'b0);

    // Asynchronous reset in WAIT
    #1 rst_n = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, NOP, 1'b0);
    chk("async_rst_addr", imem_if.imem_addr, 32'h0);
    chk("async_rst_p4", PCplus4_F, 32'h4);
    lat = 1;
    release_rst();
    step(0, 0, 0);
    chk("restart_addr", imem_if.imem_addr, 32'h0);
    step(0, 0, 0);
    expect_out("restart_first", 1'b1, 32'h0, 32'hDEAD_0000, 1'b1);

    // Redirect with a response in hand, then PC wrap-around
    step(0, 1, 32'hFFFF_FFFC);
    expect_out("redir_rvalid", 1'b0, 32'h4, NOP, 1'b0);
    step(0, 0, 0);
    chk("wrap_req_addr", imem_if.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_p4", PCplus4_F, 32'h0);
    step(0, 0, 0);
    expect_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 1'b1);
    chk("wrap_issue", imem_if.imem_addr, 32'h0);
    step(0, 0, 0);
    expect_out("wrap_zero", 1'b1, 32'h0, 32'hDEAD_0000, 1'b1);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
